// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encoding and the writeback entry layout
// used by the writeback FIFO and downstream status logic.
package alu_pkg;

    localparam int OP_W   = 3;
    localparam int DATA_W = 8;

    typedef enum logic [OP_W-1:0] {
        ADD  = 3'b000,
        SUB  = 3'b001,
        SHL  = 3'b010,
        SHR  = 3'b011,
        AND  = 3'b100,
        OR   = 3'b101,
        XOR  = 3'b110,
        NOTA = 3'b111
    } alu_op_e;

    // Flags travel with the result so the consumer never recomputes them.
    typedef struct packed {
        alu_op_e             op;
        logic [DATA_W-1:0]   result;
        logic                zero;
        logic                neg;
    } wb_entry_t;

endpackage

// File: rtl/alu_writeback_fifo_if.sv
// Producer/consumer bundle for the ALU writeback FIFO; master is the
// ALU-plus-consumer side, slave is the FIFO itself.
interface alu_writeback_fifo_if #(
    parameter int DEPTH  = 8,
    parameter int DATA_W = 8,
    parameter int OP_W   = 3
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    // Valid/ready: a transfer happens on a rising clock edge where both
    // valid and ready are high; a source holding valid may not be forced
    // to wait on a combinational path from its own valid to ready.
    logic              in_valid;
    logic [OP_W-1:0]   in_op;
    logic [DATA_W-1:0] in_result;
    logic              in_ready;

    logic              out_valid;
    logic              out_ready;
    logic [OP_W-1:0]   out_op;
    logic [DATA_W-1:0] out_result;
    logic              out_zero;
    logic              out_neg;

    logic [CNT_W-1:0]  count;
    logic              overflow;
    logic [DATA_W-1:0] last_result;

    modport master (
        output in_valid, in_op, in_result, out_ready,
        input  in_ready, out_valid, out_op, out_result, out_zero, out_neg,
        input  count, overflow, last_result
    );

    modport slave (
        input  in_valid, in_op, in_result, out_ready,
        output in_ready, out_valid, out_op, out_result, out_zero, out_neg,
        output count, overflow, last_result
    );

endinterface

// File: rtl/wb_flags.sv
// Combinational zero/negative flag generator for an ALU result.
module wb_flags
    import alu_pkg::*;
#(
    parameter int W = DATA_W
) (
    input  logic [W-1:0] result,
    output logic         zero,
    output logic         neg
);

    assign zero = (result == '0);
    assign neg  = result[W-1];

endmodule

// File: rtl/alu_writeback_fifo.sv
// ALU writeback stage: captures {op, result, flags} into a DEPTH-entry FIFO
// and tracks the most recently accepted result.
module alu_writeback_fifo
    import alu_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                clock,
    input  logic                reset,
    alu_writeback_fifo_if.slave bus
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count_q;
    logic              overflow_q;
    logic [DATA_W-1:0] last_q;

    wb_entry_t mem [DEPTH];
    wb_entry_t new_entry;
    wb_entry_t head;

    logic full;
    logic empty;
    logic push;
    logic pop;
    logic in_zero;
    logic in_neg;

    // Full/empty come from the occupancy count so pointers can wrap freely.
    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);
    assign push  = bus.in_valid & ~full;
    assign pop   = bus.out_ready & ~empty;

    wb_flags #(.W(DATA_W)) u_flags (
        .result (bus.in_result),
        .zero   (in_zero),
        .neg    (in_neg)
    );

    always_comb begin
        new_entry        = '0;
        new_entry.op     = alu_op_e'(bus.in_op);
        new_entry.result = bus.in_result;
        new_entry.zero   = in_zero;
        new_entry.neg    = in_neg;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            last_q     <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
                last_q <= bus.in_result;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            if (bus.in_valid & full) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // Storage is left unreset; validity is tracked entirely by count.
    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= new_entry;
        end
    end

    assign head = mem[rd_ptr];

    assign bus.in_ready    = ~full;
    assign bus.out_valid   = ~empty;
    assign bus.out_op      = empty ? '0 : head.op;
    assign bus.out_result  = empty ? '0 : head.result;
    assign bus.out_zero    = ~empty & head.zero;
    assign bus.out_neg     = ~empty & head.neg;
    assign bus.count       = count_q;
    assign bus.overflow    = overflow_q;
    assign bus.last_result = last_q;

endmodule

// File: tb/tb_alu_writeback_fifo.sv
// Directed bench for alu_writeback_fifo: single push, flags, fill/overflow,
// concurrent push/pop, pointer wrap and asynchronous mid-run reset.
module tb_alu_writeback_fifo;
    import alu_pkg::*;

    logic clock;
    logic reset;
    int   errors = 0;
    int   checks = 0;
    logic [7:0] exp_q[$];
    logic [7:0] exp_v;

    alu_writeback_fifo_if #(.DEPTH(8), .DATA_W(8), .OP_W(3)) bus ();

    alu_writeback_fifo #(.DEPTH(8)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    // ---------------- clock / reset ----------------
    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        bus.in_valid  = 1'b0;
        bus.in_op     = 3'b000;
        bus.in_result = 8'h00;
        bus.out_ready = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic push(input logic [2:0] op, input logic [7:0] val);
        bus.in_valid  = 1'b1;
        bus.in_op     = op;
        bus.in_result = val;
        tick();
        bus.in_valid  = 1'b0;
    endtask

    task automatic pop_one();
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        idle();
        reset = 1'b1;
        #2;
        checks++; if (bus.count !== 4'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", bus.count); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready); end
        checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b expected 0", bus.overflow); end
        checks++; if (bus.last_result !== 8'h00) begin errors++; $display("FAIL reset_last: got %h expected 00", bus.last_result); end
        checks++; if (bus.out_result !== 8'h00) begin errors++; $display("FAIL reset_out_result: got %h expected 00", bus.out_result); end
        tick();
        reset = 1'b0;
    endtask

    task automatic test_single_push();
        do_reset();
        push(3'b000, 8'h16);
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b expected 1", bus.out_valid); end
        checks++; if (bus.out_result !== 8'h16) begin errors++; $display("FAIL single_result: got %h expected 16", bus.out_result); end
        checks++; if (bus.out_op !== 3'b000) begin errors++; $display("FAIL single_op: got %b expected 000", bus.out_op); end
        checks++; if ({bus.out_zero, bus.out_neg} !== 2'b00) begin errors++; $display("FAIL single_flags: got %b expected 00", {bus.out_zero, bus.out_neg}); end
        checks++; if (bus.count !== 4'd1) begin errors++; $display("FAIL single_count: got %0d expected 1", bus.count); end
        checks++; if (bus.last_result !== 8'h16) begin errors++; $display("FAIL single_last: got %h expected 16", bus.last_result); end
        pop_one();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL single_drained: got %b expected 0", bus.out_valid); end
        checks++; if (bus.out_op !== 3'b000) begin errors++; $display("FAIL single_op_forced: got %b expected 000", bus.out_op); end
    endtask

    task automatic test_flags();
        do_reset();
        push(3'b010, 8'h80);
        push(3'b110, 8'h00);
        checks++; if (bus.out_op !== 3'b010) begin errors++; $display("FAIL flags_op1: got %b expected 010", bus.out_op); end
        checks++; if ({bus.out_zero, bus.out_neg} !== 2'b01) begin errors++; $display("FAIL flags_head1: got zn=%b expected 01", {bus.out_zero, bus.out_neg}); end
        pop_one();
        checks++; if (bus.out_op !== 3'b110) begin errors++; $display("FAIL flags_op2: got %b expected 110", bus.out_op); end
        checks++; if ({bus.out_zero, bus.out_neg} !== 2'b10) begin errors++; $display("FAIL flags_head2: got zn=%b expected 10", {bus.out_zero, bus.out_neg}); end
        checks++; if (bus.count !== 4'd1) begin errors++; $display("FAIL flags_count: got %0d expected 1", bus.count); end
        pop_one();
        checks++; if (bus.out_zero !== 1'b0) begin errors++; $display("FAIL flags_zero_forced: got %b expected 0", bus.out_zero); end
    endtask

    task automatic test_fill_overflow();
        do_reset();
        for (int i = 1; i <= 8; i++) push(3'b001, 8'(i));
        checks++; if (bus.count !== 4'd8) begin errors++; $display("FAIL fill_count: got %0d expected 8", bus.count); end
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL fill_in_ready: got %b expected 0", bus.in_ready); end
        checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL fill_no_overflow: got %b expected 0", bus.overflow); end
        push(3'b001, 8'h09);
        checks++; if (bus.overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b expected 1", bus.overflow); end
        checks++; if (bus.count !== 4'd8) begin errors++; $display("FAIL ovf_count: got %0d expected 8", bus.count); end
        checks++; if (bus.last_result !== 8'h08) begin errors++; $display("FAIL ovf_last: got %h expected 08", bus.last_result); end
        // pop while full with a push offered: only the pop happens
        bus.in_valid  = 1'b1;
        bus.in_result = 8'h55;
        pop_one();
        bus.in_valid  = 1'b0;
        checks++; if (bus.count !== 4'd7) begin errors++; $display("FAIL full_poppush_count: got %0d expected 7", bus.count); end
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL full_poppush_ready: got %b expected 1", bus.in_ready); end
        checks++; if (bus.last_result !== 8'h08) begin errors++; $display("FAIL full_poppush_last: got %h expected 08", bus.last_result); end
        for (int i = 2; i <= 8; i++) begin
            checks++; if (bus.out_result !== 8'(i)) begin errors++; $display("FAIL drain_order: got %h expected %h", bus.out_result, 8'(i)); end
            pop_one();
        end
        checks++; if (bus.count !== 4'd0) begin errors++; $display("FAIL drain_count: got %0d expected 0", bus.count); end
        checks++; if (bus.overflow !== 1'b1) begin errors++; $display("FAIL drain_overflow_sticky: got %b expected 1", bus.overflow); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        exp_q.delete();
        for (int i = 0; i < 3; i++) begin
            push(3'b011, 8'(8'h10 + i));
            exp_q.push_back(8'(8'h10 + i));
        end
        for (int k = 0; k < 10; k++) begin
            bus.in_valid  = 1'b1;
            bus.in_op     = 3'b101;
            bus.in_result = 8'(8'h20 + k);
            bus.out_ready = 1'b1;
            exp_v = exp_q.pop_front();
            checks++; if (bus.out_result !== exp_v) begin errors++; $display("FAIL b2b_order: got %h expected %h", bus.out_result, exp_v); end
            exp_q.push_back(8'(8'h20 + k));
            tick();
            checks++; if (bus.count !== 4'd3) begin errors++; $display("FAIL b2b_count: got %0d expected 3", bus.count); end
        end
        idle();
        while (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
            checks++; if (bus.out_result !== exp_v) begin errors++; $display("FAIL b2b_drain: got %h expected %h", bus.out_result, exp_v); end
            pop_one();
        end
    endtask

    task automatic test_wrap();
        int sent;
        int got;
        do_reset();
        exp_q.delete();
        sent = 0;
        got  = 0;
        for (int cyc = 0; cyc < 200 && got < 20; cyc++) begin
            bus.out_ready = (cyc % 2 == 0);
            bus.in_valid  = (sent < 20) && bus.in_ready;
            bus.in_result = 8'h40 + sent[7:0];
            bus.in_op     = sent[2:0];
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL wrap_unexpected: got %h expected nothing", bus.out_result);
                end else begin
                    exp_v = exp_q.pop_front();
                    checks++; if (bus.out_result !== exp_v) begin errors++; $display("FAIL wrap_order: got %h expected %h", bus.out_result, exp_v); end
                end
                got++;
            end
            if (bus.in_valid) begin
                exp_q.push_back(bus.in_result);
                sent++;
            end
            tick();
        end
        idle();
        checks++; if (got !== 20) begin errors++; $display("FAIL wrap_received: got %0d expected 20", got); end
        checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL wrap_overflow: got %b expected 0", bus.overflow); end
        checks++; if (bus.count !== 4'd0) begin errors++; $display("FAIL wrap_count: got %0d expected 0", bus.count); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 9; i++) push(3'b100, 8'(8'hC0 + i));
        for (int i = 0; i < 3; i++) pop_one();
        checks++; if (bus.count !== 4'd5) begin errors++; $display("FAIL mid_pre_count: got %0d expected 5", bus.count); end
        #2;
        reset = 1'b1;
        #1;
        checks++; if (bus.count !== 4'd0) begin errors++; $display("FAIL mid_count: got %0d expected 0", bus.count); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL mid_out_valid: got %b expected 0", bus.out_valid); end
        checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL mid_overflow: got %b expected 0", bus.overflow); end
        checks++; if (bus.out_result !== 8'h00) begin errors++; $display("FAIL mid_out_result: got %h expected 00", bus.out_result); end
        reset = 1'b0;
        tick();
        push(3'b111, 8'hAA);
        checks++; if (bus.out_result !== 8'hAA) begin errors++; $display("FAIL mid_after_head: got %h expected aa", bus.out_result); end
        checks++; if (bus.count !== 4'd1) begin errors++; $display("FAIL mid_after_count: got %0d expected 1", bus.count); end
        checks++; if (bus.out_neg !== 1'b1) begin errors++; $display("FAIL mid_after_neg: got %b expected 1", bus.out_neg); end
    endtask

    // ---------------- sequence / report ----------------
    initial begin
        test_reset();
        test_single_push();
        test_flags();
        test_fill_overflow();
        test_back_to_back();
        test_wrap();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
